// File: rtl/led_bank_arbiter.sv
// Time-slice arbiter sharing one 8-bit LED bank among NUM_SRC requesters.
// Round-robin slices, PR-source masking while decoupled, and a sticky alarm blink override.
module led_bank_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int SLICE_CYCLES = 12500000,
  parameter int BLINK_BIT    = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_pattern,
  input  logic                 pr_decouple,
  input  logic                 alarm,
  input  logic                 alarm_clr,
  output logic [7:0]           LED_out,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 alarm_active
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SW = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
  localparam int BW = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE,
    ST_ALARM
  } state_t;

  state_t             r_state,        w_state_nxt;
  logic [7:0]         r_led,          w_led_nxt;
  logic [NUM_SRC-1:0] r_grant,        w_grant_nxt;
  logic               r_alarm_active, w_alarm_active_nxt;
  logic [IW-1:0]      r_rr_ptr,       w_rr_ptr_nxt;
  logic [IW-1:0]      r_gidx,         w_gidx_nxt;
  logic [SW-1:0]      r_slice_cnt,    w_slice_cnt_nxt;
  logic [BW-1:0]      r_blink_cnt;

  logic [NUM_SRC-1:0] w_eff_req;
  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_win_next_ptr;
  logic [7:0]         w_pat_win;
  logic [7:0]         w_pat_g;
  logic [7:0]         w_blink_led;
  logic               w_rotate;

  // The PR region's request is meaningless while its outputs are decoupled.
  assign w_eff_req = src_req & ~{{(NUM_SRC-1){1'b0}}, pr_decouple};

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_found && w_eff_req[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  assign w_win_next_ptr = (w_win == IW'(NUM_SRC - 1)) ? '0 : w_win + IW'(1);
  assign w_pat_win      = src_pattern[{w_win, 3'b000} +: 8];
  assign w_pat_g        = src_pattern[{r_gidx, 3'b000} +: 8];
  assign w_blink_led    = r_blink_cnt[BLINK_BIT] ? 8'h00 : 8'hFF;
  // Dropout and slice expiry on the same edge fold into a single rotation.
  assign w_rotate       = !w_eff_req[r_gidx] || (r_slice_cnt == SW'(SLICE_CYCLES - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_state_nxt        = r_state;
    w_led_nxt          = r_led;
    w_grant_nxt        = r_grant;
    w_alarm_active_nxt = r_alarm_active;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_gidx_nxt         = r_gidx;
    w_slice_cnt_nxt    = r_slice_cnt;

    if (alarm) begin
      w_state_nxt        = ST_ALARM;
      w_led_nxt          = w_blink_led;
      w_grant_nxt        = '0;
      w_alarm_active_nxt = 1'b1;
      w_slice_cnt_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_led_nxt   = 8'h00;
          w_grant_nxt = '0;
          if (w_found) begin
            w_state_nxt     = ST_SERVE;
            w_led_nxt       = w_pat_win;
            w_grant_nxt     = NUM_SRC'(1) << w_win;
            w_gidx_nxt      = w_win;
            w_rr_ptr_nxt    = w_win_next_ptr;
            w_slice_cnt_nxt = '0;
          end
        end
        ST_SERVE: begin
          w_led_nxt       = w_pat_g;
          w_slice_cnt_nxt = r_slice_cnt + SW'(1);
          if (w_rotate) begin
            if (w_found) begin
              w_led_nxt       = w_pat_win;
              w_grant_nxt     = NUM_SRC'(1) << w_win;
              w_gidx_nxt      = w_win;
              w_rr_ptr_nxt    = w_win_next_ptr;
              w_slice_cnt_nxt = '0;
            end else begin
              w_state_nxt     = ST_IDLE;
              w_led_nxt       = 8'h00;
              w_grant_nxt     = '0;
              w_slice_cnt_nxt = '0;
            end
          end
        end
        ST_ALARM: begin
          w_led_nxt          = w_blink_led;
          w_grant_nxt        = '0;
          w_alarm_active_nxt = 1'b1;
          if (alarm_clr) begin
            w_state_nxt        = ST_IDLE;
            w_led_nxt          = 8'h00;
            w_alarm_active_nxt = 1'b0;
            w_slice_cnt_nxt    = '0;
          end
        end
        default: begin
          w_state_nxt        = ST_IDLE;
          w_led_nxt          = 8'h00;
          w_grant_nxt        = '0;
          w_alarm_active_nxt = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_led          <= 8'h00;
      r_grant        <= '0;
      r_alarm_active <= 1'b0;
      r_rr_ptr       <= '0;
      r_gidx         <= '0;
      r_slice_cnt    <= '0;
      r_blink_cnt    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_led          <= w_led_nxt;
      r_grant        <= w_grant_nxt;
      r_alarm_active <= w_alarm_active_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_gidx         <= w_gidx_nxt;
      r_slice_cnt    <= w_slice_cnt_nxt;
      r_blink_cnt    <= r_blink_cnt + BW'(1);
    end
  end

  assign LED_out      = r_led;
  assign grant        = r_grant;
  assign alarm_active = r_alarm_active;

endmodule
